multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 50 +++++
 rtl/fetch_timer.sv | 54 +++++
 rtl/multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// cpu_ctrl_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the multicycle control unit and its fetch timer:
//   - state_e    : controller state encoding (3 bits, codes 6..7 unused)
//   - OPC_*      : recognised instruction opcodes (instruction bits [6:0])
//   - ALUOP_*    : ALUOp codes handed to the ALU control block
//   - TIMER_W    : width of the fetch wait counter (covers timeouts up to 255)
//   - decode_alu : opcode -> {legal, alu_src, alu_op} helper
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [1:0] ALUOP_NONE = 2'b00;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_I    = 2'b11;

    localparam int TIMER_W = 8;

    typedef struct packed {
        logic       legal;
        logic       alu_src;
        logic [1:0] alu_op;
    } alu_ctrl_t;

    // Unrecognised opcodes decode to all-zero ALU controls so nothing
    // downstream sees stale values while the illegal pulse is raised.
    function automatic alu_ctrl_t decode_alu(input logic [6:0] opcode);
        alu_ctrl_t r;
        r = '{legal: 1'b0, alu_src: 1'b0, alu_op: ALUOP_NONE};
        unique case (opcode)
            OPC_R:   r = '{legal: 1'b1, alu_src: 1'b0, alu_op: ALUOP_R};
            OPC_I:   r = '{legal: 1'b1, alu_src: 1'b1, alu_op: ALUOP_I};
            default: r = '{legal: 1'b0, alu_src: 1'b0, alu_op: ALUOP_NONE};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// ============================================================================
// fetch_timer
// ----------------------------------------------------------------------------
// Counts consecutive FETCH cycles that ended without an instruction-memory
// acknowledge. expired_o is high during the IMEM_TIMEOUT-th such cycle, so the
// controller can still accept an ack arriving in that very cycle.
//
// Parameters
//   IMEM_TIMEOUT : number of un-acked FETCH cycles allowed (2..255)
// Ports
//   clk_i     in  clock, rising edge
//   rst_i     in  synchronous active-high reset, clears the count
//   clear_i   in  zero the count (asserted whenever not in FETCH)
//   enable_i  in  count this cycle (FETCH without ack)
//   expired_o out current cycle is the last one allowed
// ============================================================================
module fetch_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(IMEM_TIMEOUT - 1);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    assign expired_o = (cnt_q == LAST_CNT);

    // Saturate at the last value; the controller leaves FETCH on expiry anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// ----------------------------------------------------------------------------
// Control FSM for a multicycle RISC-V style datapath:
//   IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH/IDLE
// An unrecognised opcode skips the instruction (PC+4, illegal pulse) from
// DECODE. A FETCH that waits IMEM_TIMEOUT cycles without an ack enters HALT,
// sets the sticky fetch error, and only a reset leaves it.
//
// Optional feature (macro MULTICYCLE_PERF_CNT_EN): adds cycle_cnt_o (busy
// cycles) and instret_o (retired instructions), 32-bit wrapping counters.
//
// Parameters
//   IMEM_TIMEOUT : max un-acked FETCH cycles before HALT (2..255)
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   start_i      in   run enable (level); sampled at instruction boundaries
//   opcode_i     in   instruction register bits [6:0]
//   imem_ack_i   in   instruction memory data valid (used only in FETCH)
//   imem_req_o   out  fetch request
//   ir_we_o      out  instruction register load strobe
//   pc_we_o      out  PC <= PC+4 strobe
//   reg_we_o     out  register file write enable
//   alu_src_o    out  0 = RS2, 1 = sign-extended immediate
//   alu_op_o     out  ALUOp
//   busy_o       out  state is neither IDLE nor HALT
//   illegal_o    out  one-cycle illegal-opcode pulse in DECODE
//   fetch_err_o  out  sticky fetch timeout flag
//   state_o      out  current state encoding
//   cycle_cnt_o  out  busy cycle count          (perf counters only)
//   instret_o    out  retired instruction count (perf counters only)
// ============================================================================
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int IMEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [6:0]  opcode_i,
    input  logic        imem_ack_i,
    output logic        imem_req_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        reg_we_o,
    output logic        alu_src_o,
    output logic [1:0]  alu_op_o,
    output logic        busy_o,
    output logic        illegal_o,
    output logic        fetch_err_o,
    output logic [2:0]  state_o
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_o
`endif
);

    state_e     state_q;
    state_e     state_d;
    logic       alu_src_q;
    logic       alu_src_d;
    logic [1:0] alu_op_q;
    logic [1:0] alu_op_d;
    logic       fetch_err_q;
    logic       fetch_err_d;

    logic       timer_clear;
    logic       timer_en;
    logic       timer_expired;
    alu_ctrl_t  dec;

    assign dec = decode_alu(opcode_i);

    // Counter restarts from zero on every FETCH entry because it is held
    // clear in every other state.
    assign timer_clear = (state_q != ST_FETCH);
    assign timer_en    = (state_q == ST_FETCH) && !imem_ack_i;

    fetch_timer #(
        .IMEM_TIMEOUT (IMEM_TIMEOUT)
    ) u_fetch_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        alu_src_d   = 1'b0;
        alu_op_d    = ALUOP_NONE;
        fetch_err_d = fetch_err_q;
        imem_req_o  = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        reg_we_o    = 1'b0;
        alu_src_o   = 1'b0;
        alu_op_o    = ALUOP_NONE;
        busy_o      = 1'b0;
        illegal_o   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                busy_o     = 1'b1;
                imem_req_o = 1'b1;
                // An ack in the expiry cycle still counts as a normal fetch.
                if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    fetch_err_d = 1'b1;
                    state_d     = ST_HALT;
                end
            end

            ST_DECODE: begin
                busy_o    = 1'b1;
                alu_src_o = dec.alu_src;
                alu_op_o  = dec.alu_op;
                // Capture the controls so EXECUTE/WRITEBACK see them even if
                // the opcode bus moves after this cycle.
                alu_src_d = dec.alu_src;
                alu_op_d  = dec.alu_op;
                if (dec.legal) begin
                    state_d = ST_EXECUTE;
                end else begin
                    illegal_o = 1'b1;
                    pc_we_o   = 1'b1;
                    state_d   = start_i ? ST_FETCH : ST_IDLE;
                end
            end

            ST_EXECUTE: begin
                busy_o    = 1'b1;
                alu_src_o = alu_src_q;
                alu_op_o  = alu_op_q;
                alu_src_d = alu_src_q;
                alu_op_d  = alu_op_q;
                state_d   = ST_WRITEBACK;
            end

            ST_WRITEBACK: begin
                busy_o    = 1'b1;
                alu_src_o = alu_src_q;
                alu_op_o  = alu_op_q;
                reg_we_o  = 1'b1;
                pc_we_o   = 1'b1;
                state_d   = start_i ? ST_FETCH : ST_IDLE;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            alu_src_q   <= 1'b0;
            alu_op_q    <= ALUOP_NONE;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_src_q   <= alu_src_d;
            alu_op_q    <= alu_op_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err_o = fetch_err_q;
    assign state_o     = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
    logic [31:0] cycle_cnt_q;
    logic [31:0] cycle_cnt_d;
    logic [31:0] instret_q;
    logic [31:0] instret_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instret_d   = instret_q;
        if (busy_o) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
        if (state_q == ST_WRITEBACK) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_q <= '0;
            instret_q   <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instret_q   <= instret_d;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instret_o   = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl
// ----------------------------------------------------------------------------
// Directed stimulus with hand-written per-cycle expectations. The stimulus
// process drives inputs shortly after each rising edge and queues the outputs
// the DUT must show during that cycle; a monitor pops and compares on the
// falling edge.
// Expected vector layout: {state[2:0], imem_req, ir_we, pc_we, reg_we,
//                          alu_src, alu_op[1:0], busy, illegal, fetch_err}
// ============================================================================
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [6:0]  opcode_i = 7'd0;
    logic        imem_ack_i = 1'b0;
    logic        imem_req_o;
    logic        ir_we_o;
    logic        pc_we_o;
    logic        reg_we_o;
    logic        alu_src_o;
    logic [1:0]  alu_op_o;
    logic        busy_o;
    logic        illegal_o;
    logic        fetch_err_o;
    logic [2:0]  state_o;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt_o;
    logic [31:0] instret_o;
`endif

    always #5 clk_i = ~clk_i;

    multicycle_ctrl #(.IMEM_TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .opcode_i    (opcode_i),
        .imem_ack_i  (imem_ack_i),
        .imem_req_o  (imem_req_o),
        .ir_we_o     (ir_we_o),
        .pc_we_o     (pc_we_o),
        .reg_we_o    (reg_we_o),
        .alu_src_o   (alu_src_o),
        .alu_op_o    (alu_op_o),
        .busy_o      (busy_o),
        .illegal_o   (illegal_o),
        .fetch_err_o (fetch_err_o),
        .state_o     (state_o)
`ifdef MULTICYCLE_PERF_CNT_EN
        ,
        .cycle_cnt_o (cycle_cnt_o),
        .instret_o   (instret_o)
`endif
    );

    typedef struct {
        logic [12:0] v;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [12:0] obs;
    assign obs = {state_o, imem_req_o, ir_we_o, pc_we_o, reg_we_o,
                  alu_src_o, alu_op_o, busy_o, illegal_o, fetch_err_o};

    function automatic logic [12:0] e(input logic [2:0] st, input logic req,
                                      input logic irwe, input logic pcwe,
                                      input logic regwe, input logic src,
                                      input logic [1:0] aop, input logic busy,
                                      input logic ill, input logic ferr);
        return {st, req, irwe, pcwe, regwe, src, aop, busy, ill, ferr};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic cyc(input logic r, input logic s, input logic a,
                       input logic [6:0] op, input logic [12:0] ex,
                       input string nm);
        exp_t item;
        @(posedge clk_i);
        #1;
        rst_i      = r;
        start_i    = s;
        imem_ack_i = a;
        opcode_i   = op;
        item.v     = ex;
        item.name  = nm;
        sb_q.push_back(item);
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                checks++;
                if (obs !== x.v) begin
                    errors++;
                    $display("FAIL %s: outputs %b, required %b (t=%0t)",
                             x.name, obs, x.v, $time);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

    localparam logic [6:0] OPC_BAD = 7'b1111111;

    initial begin
        logic [12:0] idle_e, fwait_e, fack_e, halt_e;
        logic [12:0] rdec_e, rexe_e, rwb_e, idec_e, iexe_e, iwb_e, illdec_e;
        idle_e   = e(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        fwait_e  = e(3'd1, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0);
        fack_e   = e(3'd1, 1, 1, 0, 0, 0, 2'b00, 1, 0, 0);
        rdec_e   = e(3'd2, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0);
        rexe_e   = e(3'd3, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0);
        rwb_e    = e(3'd4, 0, 0, 1, 1, 0, 2'b10, 1, 0, 0);
        idec_e   = e(3'd2, 0, 0, 0, 0, 1, 2'b11, 1, 0, 0);
        iexe_e   = e(3'd3, 0, 0, 0, 0, 1, 2'b11, 1, 0, 0);
        iwb_e    = e(3'd4, 0, 0, 1, 1, 1, 2'b11, 1, 0, 0);
        illdec_e = e(3'd2, 0, 0, 1, 0, 0, 2'b00, 1, 1, 0);
        halt_e   = e(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);

        repeat (2) @(posedge clk_i);

        // Reset state, then an ack while IDLE must be ignored
        cyc(1, 0, 0, OPC_R, idle_e, "reset_idle");
        cyc(0, 0, 1, OPC_R, idle_e, "idle_ack_ignored");
        cyc(0, 1, 0, OPC_R, idle_e, "idle_start");

        // R-type, zero-wait ack: 1,2,3,4 then back to FETCH
        cyc(0, 1, 1, OPC_R, fack_e, "r_fetch");
        cyc(0, 1, 0, OPC_R, rdec_e, "r_decode");
        cyc(0, 1, 1, OPC_R, rexe_e, "r_execute");
        cyc(0, 1, 0, OPC_R, rwb_e,  "r_writeback");

        // I-type with three wait cycles: 7-cycle instruction
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, OPC_I, fwait_e, "i_fetch_wait");
        cyc(0, 1, 1, OPC_I, fack_e, "i_fetch_ack");
        cyc(0, 1, 0, OPC_I, idec_e, "i_decode");
        cyc(0, 1, 0, OPC_I, iexe_e, "i_execute");
        cyc(0, 1, 0, OPC_I, iwb_e,  "i_writeback");

        // Illegal opcode: pulse in DECODE, straight back to FETCH
        cyc(0, 1, 1, OPC_BAD, fack_e,   "ill_fetch");
        cyc(0, 1, 0, OPC_BAD, illdec_e, "ill_decode");

        // Sixteen un-acked FETCH cycles -> HALT with sticky error
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, OPC_R, fwait_e, "to_fetch_wait");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, OPC_R, halt_e, "halt_hold");
        cyc(1, 1, 1, OPC_R, halt_e, "halt_rst_cycle");
        cyc(0, 1, 0, OPC_R, idle_e, "after_halt_rst");

        // Ack on the 16th cycle wins; start dropped in DECODE
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, OPC_R, fwait_e, "edge_fetch_wait");
        cyc(0, 1, 1, OPC_R, fack_e, "edge_fetch_ack16");
        cyc(0, 0, 0, OPC_R, rdec_e, "stop_decode");
        cyc(0, 0, 0, OPC_R, rexe_e, "stop_execute");
        cyc(0, 0, 0, OPC_R, rwb_e,  "stop_writeback");
        cyc(0, 0, 0, OPC_R, idle_e, "stop_idle");

        // Reset in EXECUTE beats start and ack
        cyc(0, 1, 0, OPC_I, idle_e, "rx_idle");
        cyc(0, 1, 1, OPC_I, fack_e, "rx_fetch");
        cyc(0, 1, 0, OPC_I, idec_e, "rx_decode");
        cyc(1, 1, 1, OPC_I, iexe_e, "rx_execute_rst");
        cyc(0, 0, 0, OPC_I, idle_e, "rx_after_rst");

`ifdef MULTICYCLE_PERF_CNT_EN
        // Three back-to-back zero-wait R instructions
        cyc(1, 0, 0, OPC_R, idle_e, "perf_rst");
        cyc(0, 1, 0, OPC_R, idle_e, "perf_idle");
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, OPC_R, fack_e, "perf_fetch");
            cyc(0, 1, 0, OPC_R, rdec_e, "perf_decode");
            cyc(0, 1, 0, OPC_R, rexe_e, "perf_execute");
            cyc(0, (k < 2) ? 1'b1 : 1'b0, 0, OPC_R, rwb_e, "perf_writeback");
        end
        cyc(0, 0, 0, OPC_R, idle_e, "perf_done");
        @(negedge clk_i);
        #1;
        checks++;
        if (instret_o !== 32'd3) begin
            errors++;
            $display("FAIL perf_instret: got %0d, required 3", instret_o);
        end
        checks++;
        if (cycle_cnt_o !== 32'd12) begin
            errors++;
            $display("FAIL perf_cycle_cnt: got %0d, required 12", cycle_cnt_o);
        end
`endif

        repeat (2) @(posedge clk_i);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
